// File: rtl/cpu_pkg.sv
// Shared VeriRISC types: instruction opcodes, sequencer phases and
// the ALU-operation classifier used by the control decode.
package cpu_pkg;

    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_e;

    typedef enum logic [3:0] {
        INST_ADDR  = 4'd0,
        INST_FETCH = 4'd1,
        INST_LOAD  = 4'd2,
        IDLE       = 4'd3,
        OP_ADDR    = 4'd4,
        OP_FETCH   = 4'd5,
        ALU_OP     = 4'd6,
        STORE      = 4'd7,
        HALTED     = 4'd8
    } phase_e;

    // HALTED has no 3-bit code of its own; it reports as OP_ADDR with halt set
    localparam logic [2:0] HALTED_PHASE_CODE = 3'b100;

    function automatic logic is_aluop(input opcode_e op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational map from (phase, opcode, zero) to the eight datapath
// enables of the VeriRISC sequencer.
module ctrl_decode
    import cpu_pkg::*;
(
    input  logic [3:0] phase,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       mem_rd,
    output logic       load_ir,
    output logic       halt,
    output logic       inc_pc,
    output logic       load_ac,
    output logic       load_pc,
    output logic       mem_wr,
    output logic       data_e
);

    phase_e  ph;
    opcode_e op;
    logic    alu_op;

    assign ph     = phase_e'(phase);
    assign op     = opcode_e'(opcode);
    assign alu_op = is_aluop(op);

    always_comb begin
        mem_rd  = 1'b0;
        load_ir = 1'b0;
        halt    = 1'b0;
        inc_pc  = 1'b0;
        load_ac = 1'b0;
        load_pc = 1'b0;
        mem_wr  = 1'b0;
        data_e  = 1'b0;
        unique case (ph)
            INST_ADDR: ;
            INST_FETCH: begin
                mem_rd = 1'b1;
            end
            INST_LOAD, IDLE: begin
                mem_rd  = 1'b1;
                load_ir = 1'b1;
            end
            OP_ADDR: begin
                inc_pc = 1'b1;
                halt   = (op == HLT);
            end
            OP_FETCH: begin
                mem_rd = alu_op;
            end
            // SKZ skips the next instruction by bumping the PC a second time
            ALU_OP: begin
                mem_rd  = alu_op;
                load_ac = alu_op;
                inc_pc  = (op == SKZ) && zero;
                load_pc = (op == JMP);
                data_e  = (op == STO);
            end
            STORE: begin
                mem_rd  = alu_op;
                load_ac = alu_op;
                inc_pc  = (op == JMP);
                load_pc = (op == JMP);
                mem_wr  = (op == STO);
                data_e  = (op == STO);
            end
            HALTED: begin
                halt = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl.sv
// VeriRISC instruction sequencer: 8-phase state register with a HALTED
// state released by resume, plus a retired-instruction counter.
module cpu_ctrl
    import cpu_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           opcode,
    input  logic                 zero,
    input  logic                 resume,
    output logic                 mem_rd,
    output logic                 load_ir,
    output logic                 halt,
    output logic                 inc_pc,
    output logic                 load_ac,
    output logic                 load_pc,
    output logic                 mem_wr,
    output logic                 data_e,
    output logic [2:0]           phase,
    output logic [CNT_WIDTH-1:0] instr_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    phase_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        unique case (state_q)
            INST_ADDR:  state_d = INST_FETCH;
            INST_FETCH: state_d = INST_LOAD;
            INST_LOAD:  state_d = IDLE;
            IDLE:       state_d = OP_ADDR;
            OP_ADDR:    state_d = (opcode_e'(opcode) == HLT) ? HALTED : OP_FETCH;
            OP_FETCH:   state_d = ALU_OP;
            ALU_OP:     state_d = STORE;
            // An instruction retires as the sequencer leaves STORE
            STORE: begin
                state_d = INST_ADDR;
                count_d = count_q + CNT_ONE;
            end
            HALTED:     state_d = resume ? INST_ADDR : HALTED;
            default:    state_d = INST_ADDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INST_ADDR;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign phase       = (state_q == HALTED) ? HALTED_PHASE_CODE : state_q[2:0];
    assign instr_count = count_q;

    ctrl_decode u_decode (
        .phase   (state_q),
        .opcode  (opcode),
        .zero    (zero),
        .mem_rd  (mem_rd),
        .load_ir (load_ir),
        .halt    (halt),
        .inc_pc  (inc_pc),
        .load_ac (load_ac),
        .load_pc (load_pc),
        .mem_wr  (mem_wr),
        .data_e  (data_e)
    );

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed bench for cpu_ctrl: per-phase control vectors for each opcode
// class, halt/resume, reset dominance and counter wrap on a narrow instance.
module tb_cpu_ctrl;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  opcode = 3'd0;
    logic        zero = 1'b0;
    logic        resume = 1'b0;
    logic        mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr, data_e;
    logic [2:0]  phase;
    logic [15:0] instr_count;

    logic        w_mem_rd, w_load_ir, w_halt, w_inc_pc, w_load_ac, w_load_pc, w_mem_wr, w_data_e;
    logic [2:0]  w_phase;
    logic [3:0]  w_count;

    logic [7:0]  ctrl;
    logic [7:0]  obs_ctrl  [8];
    logic [2:0]  obs_phase [8];
    logic [7:0]  exp_ctrl  [8];

    int checks = 0;
    int errors = 0;

    assign ctrl = {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr, data_e};

    cpu_ctrl #(.CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .resume(resume),
        .mem_rd(mem_rd), .load_ir(load_ir), .halt(halt), .inc_pc(inc_pc),
        .load_ac(load_ac), .load_pc(load_pc), .mem_wr(mem_wr), .data_e(data_e),
        .phase(phase), .instr_count(instr_count)
    );

    cpu_ctrl #(.CNT_WIDTH(4)) dut_wrap (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .resume(resume),
        .mem_rd(w_mem_rd), .load_ir(w_load_ir), .halt(w_halt), .inc_pc(w_inc_pc),
        .load_ac(w_load_ac), .load_pc(w_load_pc), .mem_wr(w_mem_wr), .data_e(w_data_e),
        .phase(w_phase), .instr_count(w_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one full instruction from INST_ADDR, capturing phase and controls per cycle
    task automatic run_instr(input logic [2:0] op, input logic z);
        opcode = op;
        zero   = z;
        for (int i = 0; i < 8; i++) begin
            obs_ctrl[i]  = ctrl;
            obs_phase[i] = phase;
            tick();
        end
    endtask

    task automatic set_expect(input logic [7:0] c5, input logic [7:0] c6, input logic [7:0] c7);
        exp_ctrl[0] = 8'h00;
        exp_ctrl[1] = 8'h80;
        exp_ctrl[2] = 8'hC0;
        exp_ctrl[3] = 8'hC0;
        exp_ctrl[4] = 8'h10;
        exp_ctrl[5] = c5;
        exp_ctrl[6] = c6;
        exp_ctrl[7] = c7;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (phase !== 3'd0) begin
            errors++;
            $display("[TB] FAIL reset_phase: got %0d expected 0", phase);
        end
        checks++;
        if (ctrl !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %h expected 00", ctrl);
        end
        checks++;
        if (instr_count !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_count: got %0d expected 0", instr_count);
        end
    endtask

    task automatic test_add();
        run_instr(3'(ADD), 1'b0);
        set_expect(8'h80, 8'h88, 8'h88);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (obs_phase[i] !== 3'(i)) begin
                errors++;
                $display("[TB] FAIL add_phase[%0d]: got %0d expected %0d", i, obs_phase[i], i);
            end
            checks++;
            if (obs_ctrl[i] !== exp_ctrl[i]) begin
                errors++;
                $display("[TB] FAIL add_ctrl[%0d]: got %h expected %h", i, obs_ctrl[i], exp_ctrl[i]);
            end
        end
        checks++;
        if (instr_count !== 16'd1) begin
            errors++;
            $display("[TB] FAIL add_count: got %0d expected 1", instr_count);
        end
    endtask

    task automatic test_skz();
        run_instr(3'(SKZ), 1'b1);
        set_expect(8'h00, 8'h10, 8'h00);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (obs_ctrl[i] !== exp_ctrl[i]) begin
                errors++;
                $display("[TB] FAIL skz1_ctrl[%0d]: got %h expected %h", i, obs_ctrl[i], exp_ctrl[i]);
            end
        end
        run_instr(3'(SKZ), 1'b0);
        set_expect(8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (obs_ctrl[i] !== exp_ctrl[i]) begin
                errors++;
                $display("[TB] FAIL skz0_ctrl[%0d]: got %h expected %h", i, obs_ctrl[i], exp_ctrl[i]);
            end
        end
        checks++;
        if (instr_count !== 16'd3) begin
            errors++;
            $display("[TB] FAIL skz_count: got %0d expected 3", instr_count);
        end
    endtask

    task automatic test_sto();
        run_instr(3'(STO), 1'b1);
        set_expect(8'h00, 8'h01, 8'h03);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (obs_ctrl[i] !== exp_ctrl[i]) begin
                errors++;
                $display("[TB] FAIL sto_ctrl[%0d]: got %h expected %h", i, obs_ctrl[i], exp_ctrl[i]);
            end
        end
    endtask

    task automatic test_jmp();
        resume = 1'b1;
        run_instr(3'(JMP), 1'b0);
        resume = 1'b0;
        set_expect(8'h00, 8'h04, 8'h14);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (obs_phase[i] !== 3'(i)) begin
                errors++;
                $display("[TB] FAIL jmp_phase[%0d]: got %0d expected %0d", i, obs_phase[i], i);
            end
            checks++;
            if (obs_ctrl[i] !== exp_ctrl[i]) begin
                errors++;
                $display("[TB] FAIL jmp_ctrl[%0d]: got %h expected %h", i, obs_ctrl[i], exp_ctrl[i]);
            end
        end
        checks++;
        if (instr_count !== 16'd5) begin
            errors++;
            $display("[TB] FAIL jmp_count: got %0d expected 5", instr_count);
        end
    endtask

    task automatic test_halt();
        opcode = 3'(HLT);
        zero   = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (phase !== 3'd4 || ctrl !== 8'h30) begin
            errors++;
            $display("[TB] FAIL hlt_op_addr: got phase %0d ctrl %h expected 4 30", phase, ctrl);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (phase !== 3'd4 || ctrl !== 8'h20) begin
                errors++;
                $display("[TB] FAIL hlt_hold[%0d]: got phase %0d ctrl %h expected 4 20", i, phase, ctrl);
            end
        end
        resume = 1'b1;
        tick();
        resume = 1'b0;
        checks++;
        if (phase !== 3'd0 || ctrl !== 8'h00) begin
            errors++;
            $display("[TB] FAIL hlt_resume: got phase %0d ctrl %h expected 0 00", phase, ctrl);
        end
        checks++;
        if (instr_count !== 16'd5) begin
            errors++;
            $display("[TB] FAIL hlt_count: got %0d expected 5", instr_count);
        end
        run_instr(3'(ADD), 1'b0);
        checks++;
        if (instr_count !== 16'd6) begin
            errors++;
            $display("[TB] FAIL post_resume_count: got %0d expected 6", instr_count);
        end
    endtask

    task automatic test_reset_dominance();
        opcode = 3'(ADD);
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (phase !== 3'd6) begin
            errors++;
            $display("[TB] FAIL mid_phase: got %0d expected 6", phase);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (phase !== 3'd0 || ctrl !== 8'h00 || instr_count !== 16'd0) begin
            errors++;
            $display("[TB] FAIL rst_alu_op: got phase %0d ctrl %h count %0d expected 0 00 0", phase, ctrl, instr_count);
        end
        run_instr(3'(ADD), 1'b0);
        opcode = 3'(HLT);
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (halt !== 1'b1 || instr_count !== 16'd1) begin
            errors++;
            $display("[TB] FAIL pre_rst_halted: got halt %b count %0d expected 1 1", halt, instr_count);
        end
        rst    = 1'b1;
        resume = 1'b1;
        tick();
        rst    = 1'b0;
        resume = 1'b0;
        checks++;
        if (phase !== 3'd0 || ctrl !== 8'h00 || instr_count !== 16'd0) begin
            errors++;
            $display("[TB] FAIL rst_halted: got phase %0d ctrl %h count %0d expected 0 00 0", phase, ctrl, instr_count);
        end
        tick();
        checks++;
        if (phase !== 3'd1) begin
            errors++;
            $display("[TB] FAIL rst_halted_next: got %0d expected 1", phase);
        end
    endtask

    task automatic test_wrap();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 15; i++) run_instr(3'(LDA), 1'b0);
        checks++;
        if (w_count !== 4'hF || instr_count !== 16'd15) begin
            errors++;
            $display("[TB] FAIL wrap_pre: got narrow %h wide %0d expected f 15", w_count, instr_count);
        end
        run_instr(3'(XOR), 1'b0);
        checks++;
        if (w_count !== 4'h0 || instr_count !== 16'd16) begin
            errors++;
            $display("[TB] FAIL wrap_post: got narrow %h wide %0d expected 0 16", w_count, instr_count);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_skz();
        test_sto();
        test_jmp();
        test_halt();
        test_reset_dominance();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
